// File: rtl/rf_pkg.sv
// Shared widths, FSM state encoding and helpers for the register-file writeback arbiter.
// Imported by rf_wb_arbiter and rf_wb_hold.
package rf_pkg;

   localparam int REG_ADDR_W       = 5;
   localparam int DATA_W           = 32;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int CNT_W            = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_e;

   // Register 0 is hard-wired, so a request to it counts as no write at all.
   function automatic logic is_write(input logic en, input logic [REG_ADDR_W-1:0] addr);
      return en && (addr != '0);
   endfunction

endpackage

// File: rtl/rf_wb_hold.sv
// Single-entry holding slot for a mul/div result waiting for the register-file write port.
// A load takes priority over a clear; the arbiter never asks for both in the same cycle.
module rf_wb_hold
   import rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic [REG_ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0]     load_data,
   output logic                  valid,
   output logic [REG_ADDR_W-1:0] addr,
   output logic [DATA_W-1:0]     data
);

   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0]     data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = load_addr;
         data_d  = load_data;
      end else if (clear) begin
         valid_d = 1'b0;
         addr_d  = '0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign addr  = addr_q;
   assign data  = data_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback and a
// mul/div unit; the pipeline wins until a held mul/div result has starved too long.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_RegWrite,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  md_valid,
   input  logic [REG_ADDR_W-1:0] md_addr,
   input  logic [DATA_W-1:0]     md_data,
   output logic                  md_ready,
   output logic                  pipe_stall,
   output logic                  md_pend,
   output logic [REG_ADDR_W-1:0] md_pend_addr,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0]     wr_data
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

   arb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]     wr_data_q, wr_data_d;

   logic                  hold_load, hold_clear;
   logic                  hold_valid;
   logic [REG_ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0]     hold_data;
   logic                  wb_req, md_accept;

   rf_wb_hold u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (hold_load),
      .clear     (hold_clear),
      .load_addr (md_addr),
      .load_data (md_data),
      .valid     (hold_valid),
      .addr      (hold_addr),
      .data      (hold_data)
   );

   assign md_ready  = !hold_valid && !rst;
   assign wb_req    = is_write(wb_RegWrite, wb_addr);
   assign md_accept = md_valid && md_ready;
   assign cnt_inc   = cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      reg_write_d = 1'b0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
      hold_load   = 1'b0;
      hold_clear  = 1'b0;

      if (rst) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         hold_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wb_req) begin
                  reg_write_d = 1'b1;
                  wr_addr_d   = wb_addr;
                  wr_data_d   = wb_data;
               end
               // A mul/div result to r0 is accepted and simply dropped.
               if (md_accept && md_addr != '0) begin
                  hold_load = 1'b1;
                  state_d   = ST_WAIT;
                  cnt_d     = '0;
               end
            end
            ST_WAIT: begin
               if (wb_req) begin
                  reg_write_d = 1'b1;
                  wr_addr_d   = wb_addr;
                  wr_data_d   = wb_data;
                  // The pipeline result is younger, so the held one is dead.
                  if (wb_addr == hold_addr) begin
                     hold_clear = 1'b1;
                     state_d    = ST_IDLE;
                     cnt_d      = '0;
                  end else begin
                     cnt_d = cnt_inc;
                     if (cnt_inc >= LIMIT_M1) begin
                        state_d = ST_FORCE;
                     end
                  end
               end else begin
                  reg_write_d = 1'b1;
                  wr_addr_d   = hold_addr;
                  wr_data_d   = hold_data;
                  hold_clear  = 1'b1;
                  state_d     = ST_IDLE;
                  cnt_d       = '0;
               end
            end
            ST_FORCE: begin
               reg_write_d = 1'b1;
               wr_addr_d   = hold_addr;
               wr_data_d   = hold_data;
               hold_clear  = 1'b1;
               state_d     = ST_IDLE;
               cnt_d       = '0;
            end
            default: begin
               hold_clear = 1'b1;
               state_d    = ST_IDLE;
               cnt_d      = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         reg_write_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         reg_write_q <= reg_write_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign pipe_stall   = (state_q == ST_FORCE);
   assign md_pend      = hold_valid;
   assign md_pend_addr = hold_valid ? hold_addr : '0;
   assign RegWrite     = reg_write_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: per-cycle vector table plus hand-written
// starvation and reset-mid-hold sequences, with written results checked through a queue.
module tb_rf_wb_arbiter;

   typedef struct {
      logic        rst;
      logic        wb_we;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic        md_v;
      logic [4:0]  md_addr;
      logic [31:0] md_data;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_ready;
      logic        e_stall;
      logic        e_pend;
      logic [4:0]  e_paddr;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        wb_RegWrite;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        md_valid;
   logic [4:0]  md_addr;
   logic [31:0] md_data;
   logic        md_ready;
   logic        pipe_stall;
   logic        md_pend;
   logic [4:0]  md_pend_addr;
   logic        RegWrite;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int   checks;
   int   errors;
   int   step;
   vec_t tbl[$];
   wr_t  sb[$];

   rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_RegWrite  (wb_RegWrite),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .md_valid     (md_valid),
      .md_addr      (md_addr),
      .md_data      (md_data),
      .md_ready     (md_ready),
      .pipe_stall   (pipe_stall),
      .md_pend      (md_pend),
      .md_pend_addr (md_pend_addr),
      .RegWrite     (RegWrite),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input logic r, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                              input logic [31:0] md, input logic ewe, input logic [4:0] ea,
                              input logic [31:0] ed, input logic erdy, input logic estl,
                              input logic epnd, input logic [4:0] epa);
      vec_t x;
      x.rst = r;  x.wb_we = we; x.wb_addr = wa; x.wb_data = wd;
      x.md_v = mv; x.md_addr = ma; x.md_data = md;
      x.e_we = ewe; x.e_addr = ea; x.e_data = ed;
      x.e_ready = erdy; x.e_stall = estl; x.e_pend = epnd; x.e_paddr = epa;
      return x;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL step%0d %s: got 0x%0h expected 0x%0h", step, name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the write it should produce, and clock it in.
   task automatic applyStimulus(input vec_t x);
      wr_t w;
      rst         = x.rst;
      wb_RegWrite = x.wb_we;
      wb_addr     = x.wb_addr;
      wb_data     = x.wb_data;
      md_valid    = x.md_v;
      md_addr     = x.md_addr;
      md_data     = x.md_data;
      if (x.e_we) begin
         w.addr = x.e_addr;
         w.data = x.e_data;
         sb.push_back(w);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input vec_t x);
      wr_t w;
      cmp("RegWrite", {31'd0, RegWrite}, {31'd0, x.e_we});
      if (RegWrite === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL step%0d write: got r%0d=0x%0h expected no write", step, wr_addr, wr_data);
         end else begin
            w = sb.pop_front();
            cmp("wr_addr", {27'd0, wr_addr}, {27'd0, w.addr});
            cmp("wr_data", wr_data, w.data);
         end
      end else if (x.e_we && sb.size() != 0) begin
         void'(sb.pop_front());
      end
      if (x.rst) begin
         cmp("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
         cmp("rst_wr_data", wr_data, 32'd0);
      end
      cmp("md_ready", {31'd0, md_ready}, {31'd0, x.e_ready});
      cmp("pipe_stall", {31'd0, pipe_stall}, {31'd0, x.e_stall});
      cmp("md_pend", {31'd0, md_pend}, {31'd0, x.e_pend});
      cmp("md_pend_addr", {27'd0, md_pend_addr}, {27'd0, x.e_paddr});
   endtask

   task automatic runVec(input vec_t x);
      applyStimulus(x);
      checkOutput(x);
      step++;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      step   = 0;
      rst = 1'b1; wb_RegWrite = 1'b0; wb_addr = '0; wb_data = '0;
      md_valid = 1'b0; md_addr = '0; md_data = '0;

      //            rst we wa  wd          mv ma  md           ewe ea  ed           rdy stl pnd pa
      tbl.push_back(v(1, 0, 0,  0,          0, 0,  0,           0,  0,  0,           0,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          0, 0,  0,           0,  0,  0,           1,  0,  0,  0));
      tbl.push_back(v(0, 1, 5,  32'h1234,   0, 0,  0,           1,  5,  32'h1234,    1,  0,  0,  0));
      tbl.push_back(v(0, 1, 0,  32'hdead,   0, 0,  0,           0,  0,  0,           1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 7,  32'haaaa,    0,  0,  0,           0,  0,  1,  7));
      tbl.push_back(v(0, 0, 0,  0,          0, 0,  0,           1,  7,  32'haaaa,    1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 3,  32'h1,       0,  0,  0,           0,  0,  1,  3));
      tbl.push_back(v(0, 1, 3,  32'h2,      0, 0,  0,           1,  3,  32'h2,       1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          0, 0,  0,           0,  0,  0,           1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 0,  32'h55,      0,  0,  0,           1,  0,  0,  0));
      tbl.push_back(v(0, 1, 1,  32'h11,     1, 2,  32'h22,      1,  1,  32'h11,      0,  0,  1,  2));
      tbl.push_back(v(0, 0, 0,  0,          0, 0,  0,           1,  2,  32'h22,      1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 10, 32'hb0,      0,  0,  0,           0,  0,  1,  10));
      tbl.push_back(v(0, 0, 0,  0,          1, 11, 32'hb1,      1,  10, 32'hb0,      1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 11, 32'hb1,      0,  0,  0,           0,  0,  1,  11));
      tbl.push_back(v(0, 0, 0,  0,          0, 0,  0,           1,  11, 32'hb1,      1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 12, 32'hc,       0,  0,  0,           0,  0,  1,  12));
      tbl.push_back(v(0, 1, 0,  32'hee,     0, 0,  0,           1,  12, 32'hc,       1,  0,  0,  0));
      tbl.push_back(v(0, 0, 0,  0,          1, 13, 32'hd,       0,  0,  0,           0,  0,  1,  13));
      tbl.push_back(v(0, 1, 14, 32'he,      0, 0,  0,           1,  14, 32'he,       0,  0,  1,  13));
      tbl.push_back(v(0, 0, 0,  0,          0, 0,  0,           1,  13, 32'hd,       1,  0,  0,  0));

      for (int i = 0; i < tbl.size(); i++) begin
         runVec(tbl[i]);
      end

      $display("[TB] starvation sequence");
      runVec(v(0, 0, 0,  0,        1, 9, 32'h99,  0, 0,  0,        0, 0, 1, 9));
      runVec(v(0, 1, 20, 32'h20,   0, 0, 0,       1, 20, 32'h20,   0, 0, 1, 9));
      runVec(v(0, 1, 21, 32'h21,   0, 0, 0,       1, 21, 32'h21,   0, 0, 1, 9));
      runVec(v(0, 1, 22, 32'h22,   0, 0, 0,       1, 22, 32'h22,   0, 1, 1, 9));
      runVec(v(0, 1, 23, 32'h23,   0, 0, 0,       1, 9,  32'h99,   1, 0, 0, 0));
      runVec(v(0, 1, 23, 32'h23,   0, 0, 0,       1, 23, 32'h23,   1, 0, 0, 0));

      $display("[TB] reset while holding");
      runVec(v(0, 0, 0,  0,        1, 4, 32'h44,  0, 0,  0,        0, 0, 1, 4));
      runVec(v(1, 1, 6,  32'h66,   1, 8, 32'h88,  0, 0,  0,        0, 0, 0, 0));
      runVec(v(0, 0, 0,  0,        0, 0, 0,       0, 0,  0,        1, 0, 0, 0));
      runVec(v(0, 0, 0,  0,        0, 0, 0,       0, 0,  0,        1, 0, 0, 0));

      cmp("sb_leftover", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
